// File: rtl/ascon_block_packer.sv
// rtl/ascon_block_packer.sv - byte-serial AAD+MSG stream packed into 128-bit blocks for ascon_top
module ascon_block_packer #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    input  logic             s_empty,
    input  logic             ready_for_data,
    output logic             valid_data_in,
    output logic [127:0]     data_in,
    output logic [4:0]       valid_bytes,
    output logic             last_block,
    output logic             EOT,
    output logic             busy,
    output logic [LEN_W-1:0] aad_bytes,
    output logic [LEN_W-1:0] msg_bytes
);

    typedef enum logic [1:0] {ST_IDLE, ST_AAD, ST_MSG, ST_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [127:0]       asm_data_q, asm_data_d;
    logic [4:0]         asm_cnt_q, asm_cnt_d;
    logic               asm_full_q, asm_full_d;
    logic               asm_last_q, asm_last_d;
    logic               asm_eot_q, asm_eot_d;
    logic               out_full_q, out_full_d;
    logic [127:0]       out_data_q, out_data_d;
    logic [4:0]         out_vb_q, out_vb_d;
    logic               out_last_q, out_last_d;
    logic               out_eot_q, out_eot_d;
    logic [LEN_W-1:0]   aad_cnt_q, aad_cnt_d;
    logic [LEN_W-1:0]   msg_cnt_q, msg_cnt_d;

    logic in_seg;
    logic accept;
    logic byte_beat;
    logic seg_end;
    logic close_beat;
    logic load;

    assign in_seg     = (state_q == ST_AAD) || (state_q == ST_MSG);
    assign s_ready    = in_seg && !asm_full_q;
    assign accept     = s_valid && s_ready;
    // an s_empty beat never carries a byte; without s_last it is dropped entirely
    assign byte_beat  = accept && !s_empty;
    assign seg_end    = accept && s_last;
    assign close_beat = seg_end || (byte_beat && (asm_cnt_q == 5'd15));
    assign valid_data_in = out_full_q && ready_for_data;
    assign load       = asm_full_q && (!out_full_q || valid_data_in);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_AAD;
            ST_AAD:   if (seg_end) state_d = ST_MSG;
            ST_MSG:   if (seg_end) state_d = ST_FLUSH;
            ST_FLUSH: if (valid_data_in && out_eot_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // load and accept are exclusive: asm_full both enables load and blocks s_ready
    always_comb begin
        asm_data_d = asm_data_q;
        asm_cnt_d  = asm_cnt_q;
        asm_full_d = asm_full_q;
        asm_last_d = asm_last_q;
        asm_eot_d  = asm_eot_q;
        if (load) begin
            asm_data_d = '0;
            asm_cnt_d  = '0;
            asm_full_d = 1'b0;
            asm_last_d = 1'b0;
            asm_eot_d  = 1'b0;
        end else begin
            if (byte_beat) begin
                for (int i = 0; i < 16; i++) begin
                    if (asm_cnt_q == 5'(i)) asm_data_d[127-8*i -: 8] = s_data;
                end
                asm_cnt_d = asm_cnt_q + 5'd1;
            end
            if (close_beat) begin
                asm_full_d = 1'b1;
                asm_last_d = (state_q == ST_AAD) && s_last;
                asm_eot_d  = (state_q == ST_MSG) && s_last;
            end
        end
    end

    always_comb begin
        out_full_d = out_full_q;
        out_data_d = out_data_q;
        out_vb_d   = out_vb_q;
        out_last_d = out_last_q;
        out_eot_d  = out_eot_q;
        if (load) begin
            out_full_d = 1'b1;
            out_data_d = asm_data_q;
            out_vb_d   = asm_cnt_q;
            out_last_d = asm_last_q;
            out_eot_d  = asm_eot_q;
        end else if (valid_data_in) begin
            out_full_d = 1'b0;
        end
    end

    always_comb begin
        aad_cnt_d = aad_cnt_q;
        msg_cnt_d = msg_cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            aad_cnt_d = '0;
            msg_cnt_d = '0;
        end else if (byte_beat) begin
            if ((state_q == ST_AAD) && (aad_cnt_q != '1)) aad_cnt_d = aad_cnt_q + 1'b1;
            if ((state_q == ST_MSG) && (msg_cnt_q != '1)) msg_cnt_d = msg_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            asm_data_q <= '0;
            asm_cnt_q  <= '0;
            asm_full_q <= 1'b0;
            asm_last_q <= 1'b0;
            asm_eot_q  <= 1'b0;
            out_full_q <= 1'b0;
            out_data_q <= '0;
            out_vb_q   <= '0;
            out_last_q <= 1'b0;
            out_eot_q  <= 1'b0;
            aad_cnt_q  <= '0;
            msg_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            asm_data_q <= asm_data_d;
            asm_cnt_q  <= asm_cnt_d;
            asm_full_q <= asm_full_d;
            asm_last_q <= asm_last_d;
            asm_eot_q  <= asm_eot_d;
            out_full_q <= out_full_d;
            out_data_q <= out_data_d;
            out_vb_q   <= out_vb_d;
            out_last_q <= out_last_d;
            out_eot_q  <= out_eot_d;
            aad_cnt_q  <= aad_cnt_d;
            msg_cnt_q  <= msg_cnt_d;
        end
    end

    assign data_in     = out_data_q;
    assign valid_bytes = out_vb_q;
    assign last_block  = out_last_q;
    assign EOT         = out_eot_q;
    assign busy        = (state_q != ST_IDLE);
    assign aad_bytes   = aad_cnt_q;
    assign msg_bytes   = msg_cnt_q;

endmodule
